// File: rtl/c17_bist_pkg.sv
// ============================================================================
// Module : c17_bist_pkg
// Brief  : Shared types, widths and MISR helper for the c17 BIST controller.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package c17_bist_pkg;

    localparam int PAT_W   = 5;
    localparam int NUM_PAT = 32;
    localparam int SIG_W   = 8;
    localparam int CNT_W   = 6;

    // Feedback taps s[7], s[5], s[4], s[3]
    localparam logic [SIG_W-1:0] MISR_TAPS = 8'hB8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_APPLY   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] s,
                                                   input logic [1:0]       d);
        return {s[SIG_W-2:0], ^(s & MISR_TAPS)} ^ {{(SIG_W-2){1'b0}}, d};
    endfunction

endpackage

`default_nettype wire

// File: rtl/c17_golden_model.sv
// ============================================================================
// Module : c17_golden_model
// Brief  : Combinational reference c17 function; pattern {I1,I2,I3,I6,I7}.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module c17_golden_model
    import c17_bist_pkg::*;
(
    input  logic [PAT_W-1:0] i_pattern,
    output logic [1:0]       o_resp      // {O23, O22}
);

    logic w_i1, w_i2, w_i3, w_i6, w_i7;
    logic w_net10, w_net11, w_net16, w_net19;

    assign {w_i1, w_i2, w_i3, w_i6, w_i7} = i_pattern;

    assign w_net10 = ~(w_i1 & w_i3);
    assign w_net11 = ~(w_i3 & w_i6);
    assign w_net16 = ~(w_i2 & w_net11);
    assign w_net19 = ~(w_net11 & w_i7);

    assign o_resp = {~(w_net16 & w_net19), ~(w_net10 & w_net16)};

endmodule

`default_nettype wire

// File: rtl/c17_bist_ctrl.sv
// ============================================================================
// Module : c17_bist_ctrl
// Brief  : Exhaustive BIST for an external c17 CUT with golden compare + MISR.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module c17_bist_ctrl
    import c17_bist_pkg::*;
#(
    parameter int              SETTLE_CYCLES = 1,
    parameter logic [SIG_W-1:0] GOLDEN_SIG   = 8'h00,
    parameter bit              CHECK_SIG     = 1'b0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    output logic [PAT_W-1:0] cut_in,
    input  logic [1:0]       cut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] fail_count,
    output logic [PAT_W-1:0] first_fail,
    output logic             any_fail,
    output logic [SIG_W-1:0] signature
);

    localparam logic [3:0]       c_SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [PAT_W-1:0] c_LAST_PAT    = PAT_W'(NUM_PAT - 1);

    state_t           r_state, w_state_nxt;
    logic [3:0]       r_settle;
    logic [PAT_W-1:0] r_pattern;
    logic [CNT_W-1:0] r_fail_cnt;
    logic [PAT_W-1:0] r_first_fail;
    logic             r_any_fail;
    logic [SIG_W-1:0] r_sig;
    logic [1:0]       w_model;
    logic             w_launch;
    logic             w_mismatch;

    c17_golden_model u_model (
        .i_pattern (r_pattern),
        .o_resp    (w_model)
    );

    // A new run may be launched from IDLE or DONE; start is ignored otherwise.
    assign w_launch   = start && (r_state == ST_IDLE || r_state == ST_DONE);
    assign w_mismatch = (cut_out != w_model);

    always_ff @(posedge CLK) begin
        if (RST) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: if (start) w_state_nxt = ST_APPLY;
            ST_APPLY:         if (r_settle == c_SETTLE_LAST) w_state_nxt = ST_CAPTURE;
            ST_CAPTURE:       w_state_nxt = (r_pattern == c_LAST_PAT) ? ST_DONE : ST_APPLY;
            default:          w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_settle     <= '0;
            r_pattern    <= '0;
            r_fail_cnt   <= '0;
            r_first_fail <= '0;
            r_any_fail   <= 1'b0;
            r_sig        <= '0;
        end else if (w_launch) begin
            r_settle     <= '0;
            r_pattern    <= '0;
            r_fail_cnt   <= '0;
            r_first_fail <= '0;
            r_any_fail   <= 1'b0;
            r_sig        <= '0;
        end else if (r_state == ST_APPLY) begin
            r_settle <= r_settle + 4'd1;
        end else if (r_state == ST_CAPTURE) begin
            r_settle <= '0;
            r_sig    <= misr_step(r_sig, cut_out);
            if (w_mismatch) begin
                r_fail_cnt <= r_fail_cnt + CNT_W'(1);
                if (!r_any_fail) begin
                    r_first_fail <= r_pattern;
                    r_any_fail   <= 1'b1;
                end
            end
            // Pattern (and thus cut_in) holds at 31 once the run ends.
            if (r_pattern != c_LAST_PAT)
                r_pattern <= r_pattern + PAT_W'(1);
        end
    end

    assign cut_in     = r_pattern;
    assign busy       = (r_state == ST_APPLY) || (r_state == ST_CAPTURE);
    assign done       = (r_state == ST_DONE);
    assign pass       = done && (r_fail_cnt == '0) && (!CHECK_SIG || r_sig == GOLDEN_SIG);
    assign fail_count = r_fail_cnt;
    assign first_fail = r_first_fail;
    assign any_fail   = r_any_fail;
    assign signature  = r_sig;

endmodule

`default_nettype wire

// File: tb/tb_c17_bist_ctrl.sv
// ============================================================================
// Module : tb_c17_bist_ctrl
// Brief  : Directed self-checking bench for c17_bist_ctrl with modelled CUTs.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_c17_bist_ctrl;

    // c17 from the gate equations; pattern = {I1,I2,I3,I6,I7}, result {O23,O22}
    function automatic logic [1:0] f_c17(input logic [4:0] p);
        logic n10, n11, n16, n19;
        n10 = ~(p[4] & p[2]);
        n11 = ~(p[2] & p[1]);
        n16 = ~(p[3] & n11);
        n19 = ~(n11 & p[0]);
        return {~(n16 & n19), ~(n10 & n16)};
    endfunction

    // fault 0: good CUT, 1: O23 stuck-at-0, 2: O22 stuck-at-1
    function automatic logic [1:0] f_cut(input logic [4:0] p, input int fault);
        logic [1:0] r;
        r = f_c17(p);
        if (fault == 1) r[1] = 1'b0;
        if (fault == 2) r[0] = 1'b1;
        return r;
    endfunction

    function automatic logic [7:0] f_sig(input int fault);
        logic [7:0] s;
        logic [1:0] r;
        s = 8'h00;
        for (int p = 0; p < 32; p++) begin
            r = f_cut(5'(p), fault);
            s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]} ^ {6'b0, r};
        end
        return s;
    endfunction

    localparam logic [7:0] c_GOLD = f_sig(0);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    int   fault = 0;
    int   n_vec = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    // a: default, s: signature check good, b: signature check bad, c: settle 3
    logic [4:0] cut_in_a, cut_in_s, cut_in_b, cut_in_c;
    logic [1:0] cut_out_a, cut_out_s, cut_out_b, cut_out_c;
    logic       busy_a, busy_s, busy_b, busy_c;
    logic       done_a, done_s, done_b, done_c;
    logic       pass_a, pass_s, pass_b, pass_c;
    logic [5:0] fc_a, fc_s, fc_b, fc_c;
    logic [4:0] ff_a, ff_s, ff_b, ff_c;
    logic       af_a, af_s, af_b, af_c;
    logic [7:0] sig_a, sig_s, sig_b, sig_c;

    assign cut_out_a = f_cut(cut_in_a, fault);
    assign cut_out_s = f_cut(cut_in_s, fault);
    assign cut_out_b = f_cut(cut_in_b, fault);
    assign cut_out_c = f_cut(cut_in_c, fault);

    c17_bist_ctrl dut_a (
        .CLK(clk), .RST(rst), .start(start), .cut_in(cut_in_a), .cut_out(cut_out_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .fail_count(fc_a),
        .first_fail(ff_a), .any_fail(af_a), .signature(sig_a));

    c17_bist_ctrl #(.GOLDEN_SIG(c_GOLD), .CHECK_SIG(1'b1)) dut_s (
        .CLK(clk), .RST(rst), .start(start), .cut_in(cut_in_s), .cut_out(cut_out_s),
        .busy(busy_s), .done(done_s), .pass(pass_s), .fail_count(fc_s),
        .first_fail(ff_s), .any_fail(af_s), .signature(sig_s));

    c17_bist_ctrl #(.GOLDEN_SIG(c_GOLD ^ 8'h01), .CHECK_SIG(1'b1)) dut_b (
        .CLK(clk), .RST(rst), .start(start), .cut_in(cut_in_b), .cut_out(cut_out_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .fail_count(fc_b),
        .first_fail(ff_b), .any_fail(af_b), .signature(sig_b));

    c17_bist_ctrl #(.SETTLE_CYCLES(3)) dut_c (
        .CLK(clk), .RST(rst), .start(start), .cut_in(cut_in_c), .cut_out(cut_out_c),
        .busy(busy_c), .done(done_c), .pass(pass_c), .fail_count(fc_c),
        .first_fail(ff_c), .any_fail(af_c), .signature(sig_c));

    // Leaves the bench on the negedge just after the edge that samples start.
    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // Cycles from the start-sampling edge until done_a is seen; -1 on timeout.
    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (done_a) begin
                cyc = i;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++; if (cut_in_a !== 5'd0) begin n_fail++; $display("FAIL reset_cut_in got=%h want=00", cut_in_a); end
        n_vec++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy_a); end
        n_vec++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b want=0", done_a); end
        n_vec++; if (pass_a !== 1'b0) begin n_fail++; $display("FAIL reset_pass got=%b want=0", pass_a); end
        n_vec++; if (fc_a !== 6'd0) begin n_fail++; $display("FAIL reset_fail_count got=%0d want=0", fc_a); end
        n_vec++; if (ff_a !== 5'd0) begin n_fail++; $display("FAIL reset_first_fail got=%0d want=0", ff_a); end
        n_vec++; if (af_a !== 1'b0) begin n_fail++; $display("FAIL reset_any_fail got=%b want=0", af_a); end
        n_vec++; if (sig_a !== 8'h00) begin n_fail++; $display("FAIL reset_signature got=%h want=00", sig_a); end
        rst = 1'b0;
    endtask

    task automatic test_good_run();
        int cyc;
        fault = 0;
        pulse_start();
        n_vec++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL good_busy got=%b want=1", busy_a); end
        n_vec++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL good_done_low got=%b want=0", done_a); end
        n_vec++; if (cut_in_a !== 5'd0) begin n_fail++; $display("FAIL good_first_pat got=%h want=00", cut_in_a); end
        wait_done(cyc);
        n_vec++; if (cyc !== 64) begin n_fail++; $display("FAIL good_run_len got=%0d want=64", cyc); end
        n_vec++; if (fc_a !== 6'd0) begin n_fail++; $display("FAIL good_fail_count got=%0d want=0", fc_a); end
        n_vec++; if (af_a !== 1'b0) begin n_fail++; $display("FAIL good_any_fail got=%b want=0", af_a); end
        n_vec++; if (pass_a !== 1'b1) begin n_fail++; $display("FAIL good_pass got=%b want=1", pass_a); end
        n_vec++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL good_busy_end got=%b want=0", busy_a); end
        n_vec++; if (cut_in_a !== 5'h1F) begin n_fail++; $display("FAIL good_last_pat got=%h want=1f", cut_in_a); end
        n_vec++; if (sig_a !== c_GOLD) begin n_fail++; $display("FAIL good_signature got=%h want=%h", sig_a, c_GOLD); end
        n_vec++; if (pass_s !== 1'b1) begin n_fail++; $display("FAIL sigchk_pass got=%b want=1", pass_s); end
        n_vec++; if (pass_b !== 1'b0) begin n_fail++; $display("FAIL sigbad_pass got=%b want=0", pass_b); end
        n_vec++; if (fc_b !== 6'd0) begin n_fail++; $display("FAIL sigbad_fail_count got=%0d want=0", fc_b); end
        n_vec++; if (done_b !== 1'b1) begin n_fail++; $display("FAIL sigbad_done got=%b want=1", done_b); end
        // Outputs must hold in DONE
        repeat (5) @(negedge clk);
        n_vec++; if ({done_a, pass_a, cut_in_a} !== {1'b1, 1'b1, 5'h1F}) begin
            n_fail++; $display("FAIL good_hold got=%b%b%h want=111f", done_a, pass_a, cut_in_a); end
    endtask

    task automatic test_fault(input int f, input logic [5:0] exp_fc, input logic [4:0] exp_ff);
        int cyc;
        logic [7:0] exp_sig;
        fault = f;
        exp_sig = f_sig(f);
        pulse_start();
        wait_done(cyc);
        n_vec++; if (cyc !== 64) begin n_fail++; $display("FAIL fault%0d_run_len got=%0d want=64", f, cyc); end
        n_vec++; if (fc_a !== exp_fc) begin n_fail++; $display("FAIL fault%0d_fail_count got=%0d want=%0d", f, fc_a, exp_fc); end
        n_vec++; if (ff_a !== exp_ff) begin n_fail++; $display("FAIL fault%0d_first_fail got=%0d want=%0d", f, ff_a, exp_ff); end
        n_vec++; if (af_a !== 1'b1) begin n_fail++; $display("FAIL fault%0d_any_fail got=%b want=1", f, af_a); end
        n_vec++; if (pass_a !== 1'b0) begin n_fail++; $display("FAIL fault%0d_pass got=%b want=0", f, pass_a); end
        n_vec++; if (sig_a !== exp_sig) begin n_fail++; $display("FAIL fault%0d_signature got=%h want=%h", f, sig_a, exp_sig); end
    endtask

    task automatic test_abort_restart();
        int hit;
        int done_at_a;
        int done_at_c;
        fault = 0;
        pulse_start();
        hit = 0;
        for (int i = 0; i < 100 && hit == 0; i++) begin
            @(negedge clk);
            if (cut_in_a == 5'd10) hit = 1;
        end
        n_vec++; if (hit !== 1) begin n_fail++; $display("FAIL abort_reach_pat10 got=%0d want=1", hit); end
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        n_vec++; if ({busy_a, done_a, af_a, fc_a, cut_in_a, sig_a} !== 22'd0) begin
            n_fail++; $display("FAIL abort_reset_a got=%b%b%b %0d %h %h want=all zero",
                               busy_a, done_a, af_a, fc_a, cut_in_a, sig_a); end
        n_vec++; if ({busy_c, done_c, cut_in_c, sig_c} !== 15'd0) begin
            n_fail++; $display("FAIL abort_reset_c got=%b%b %h %h want=all zero", busy_c, done_c, cut_in_c, sig_c); end
        pulse_start();
        n_vec++; if ({busy_a, cut_in_a} !== {1'b1, 5'd0}) begin
            n_fail++; $display("FAIL restart_pat0 got=%b %h want=1 00", busy_a, cut_in_a); end
        done_at_a = -1;
        done_at_c = -1;
        for (int k = 1; k <= 300 && done_at_c < 0; k++) begin
            @(negedge clk);
            if (k == 20) start = 1'b1;
            if (k == 21) start = 1'b0;
            if (done_a && done_at_a < 0) done_at_a = k;
            if (done_c && done_at_c < 0) done_at_c = k;
        end
        n_vec++; if (done_at_a !== 64) begin n_fail++; $display("FAIL busy_start_ignored got=%0d want=64", done_at_a); end
        n_vec++; if (done_at_c !== 128) begin n_fail++; $display("FAIL settle3_run_len got=%0d want=128", done_at_c); end
        n_vec++; if (pass_a !== 1'b1) begin n_fail++; $display("FAIL restart_pass got=%b want=1", pass_a); end
        n_vec++; if (pass_c !== 1'b1) begin n_fail++; $display("FAIL settle3_pass got=%b want=1", pass_c); end
        n_vec++; if (sig_c !== c_GOLD) begin n_fail++; $display("FAIL settle3_signature got=%h want=%h", sig_c, c_GOLD); end
        n_vec++; if (fc_c !== 6'd0) begin n_fail++; $display("FAIL settle3_fail_count got=%0d want=0", fc_c); end
    endtask

    initial begin
        test_reset();
        test_good_run();
        test_fault(1, 6'd18, 5'd1);
        test_fault(2, 6'd14, 5'd0);
        test_abort_restart();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/c17_bist_ctrl.md
Name: c17_bist_ctrl

Overview:
- Built-in self-test controller for an extracted c17 gate netlist (five inputs I1,I2,I3,I6,I7; two outputs O22,O23).
- Drives all 32 input patterns exhaustively into the external combinational circuit-under-test (CUT), then reads back its responses.
- Compares each response against an internal golden c17 model and compacts all responses into an 8-bit MISR signature.
- Sits beside the extracted netlist as its stimulus/response end, so extraction can be validated in simulation or silicon.

Parameters:
- SETTLE_CYCLES, 1: cycles a pattern is held before sampling; legal range 1..15.
- GOLDEN_SIG, 8'h00: expected final MISR signature.
- CHECK_SIG, 0: 1 = pass also requires signature == GOLDEN_SIG; 0 = signature is reported only.

Ports:
- CLK  input  1  rising-edge clock
- RST  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to begin a run
- cut_in  output  5  registered pattern to CUT: {I1,I2,I3,I6,I7} = pattern[4:0]
- cut_out  input  2  CUT response {O23,O22}
- busy  output  1  run in progress
- done  output  1  run complete; held high
- pass  output  1  result, valid while done=1
- fail_count  output  6  number of mismatching patterns, 0..32
- first_fail  output  5  index of first mismatching pattern
- any_fail  output  1  at least one mismatch seen
- signature  output  8  MISR contents

Behaviour:
- Reset (RST=1 at a clock edge), effective next cycle:
  - FSM goes to IDLE.
  - cut_in, fail_count, first_fail, signature = 0; busy, done, pass, any_fail = 0.
  - Reset mid-run aborts the run. No partial results are retained.
- FSM states: IDLE, APPLY, CAPTURE, DONE.
- IDLE:
  - start=1 -> APPLY.
  - On that transition: pattern=0, fail_count=0, any_fail=0, first_fail=0, signature=0, busy=1, done=0.
- APPLY:
  - cut_in = pattern.
  - Hold for SETTLE_CYCLES cycles (settle counter), then -> CAPTURE.
- CAPTURE (one cycle):
  - Sample cut_out and compare with model(pattern).
  - On mismatch: fail_count+1; if any_fail=0, first_fail=pattern and any_fail=1.
  - Update the MISR.
  - If pattern==31 -> DONE; else pattern+1 -> APPLY.
  - The pattern counter never wraps inside a run.
- DONE:
  - busy=0, done=1.
  - pass = (fail_count==0) && (!CHECK_SIG || signature==GOLDEN_SIG).
  - Outputs hold. start=1 begins a new run exactly as from IDLE.
- start while busy: ignored, no restart.
- Run length: 32*(SETTLE_CYCLES+1) cycles from the first APPLY cycle to the DONE entry (64 at default).
- Golden model:
  - net10=~(I1&I3); net11=~(I3&I6); net16=~(I2&net11); net19=~(net11&I7).
  - O22=~(net10&net16); O23=~(net16&net19).
- MISR step, with s = current signature:
  - fb = s[7]^s[5]^s[4]^s[3].
  - next = {s[6:0],fb} ^ {6'b0, O23, O22}.
  - The sampled cut_out value is used, not the model value.
- cut_in changes only on APPLY entry. It holds its last pattern in DONE and IDLE until reset.
- cut_out X/Z in CAPTURE counts as a mismatch in simulation (use !==-style compare in the model bench only; RTL compares 2-state).

Decomposition:
- Package c17_bist_pkg: state enum, PAT_W=5, NUM_PAT=32, SIG_W=8, MISR tap constant, CNT_W=6.
- Sub-module c17_golden_model: purely combinational 5-in/2-out reference function, shared with the testbench scoreboard.
- MISR and FSM stay in the top module.

Test Plan:
- Correct CUT (bench model wired to cut_in), start pulse, SETTLE=1 -> done rises after 64 cycles; fail_count=0, any_fail=0, pass=1 (CHECK_SIG=0).
- O23 stuck-at-0 CUT -> fail_count=18, first_fail=1, any_fail=1, pass=0.
- O22 stuck-at-1 CUT -> fail_count=14, first_fail=0, pass=0.
- Spot patterns on correct CUT: pattern 0 -> cut_out 2'b00 accepted; pattern 31 -> {O23,O22}=2'b01 accepted; cut_in=5'h1F during last APPLY.
- CHECK_SIG=1 with GOLDEN_SIG set to the bench-computed correct signature -> pass=1; flip GOLDEN_SIG bit 0 -> pass=0 with fail_count=0.
- RST asserted at pattern 10, then start; also start re-pulsed while busy -> outputs return to reset values; the run restarts from pattern 0; the mid-run start causes no restart; SETTLE_CYCLES=3 run completes in 128 cycles.
